// File: rtl/reg_pkg.sv
// Register-file sizing shared by rename, retirement and the free list.
package reg_pkg;
    localparam int NUM_PHYS_REGS = 128;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PR_W = $clog2(NUM_PHYS_REGS);
    localparam int FRL_INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;

    typedef logic [PR_W-1:0] phys_reg_t;
endpackage

// File: rtl/uop_pkg.sv
// Micro-op pipeline widths shared across the front end.
package uop_pkg;
    localparam int INSTR_Q_WIDTH = 4;
endpackage

// File: rtl/free_reg_list_lane_compactor.sv
// Per-lane exclusive prefix popcount plus total popcount of a valid vector.
module lane_compactor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]                        valid,
    output logic [WIDTH-1:0][$clog2(WIDTH+1)-1:0]   prefix,
    output logic [$clog2(WIDTH+1)-1:0]              total
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            prefix[i] = acc;
            acc       = acc + CW'(valid[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/free_reg_list.sv
// Physical free register list: retirement pushes at tail, rename pops at the
// speculative head, and the retired head lets a flush rewind in one cycle.
module free_reg_list #(
    parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS = reg_pkg::NUM_ARCH_REGS,
    parameter int ALLOC_WIDTH   = uop_pkg::INSTR_Q_WIDTH,
    parameter int FREE_WIDTH    = 2 * uop_pkg::INSTR_Q_WIDTH + 2
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [FREE_WIDTH-1:0]                              free_valid,
    input  logic [FREE_WIDTH-1:0][$clog2(NUM_PHYS_REGS)-1:0]   free_regs,
    input  logic [ALLOC_WIDTH-1:0]                             alloc_req,
    output logic                                               alloc_ready,
    output logic [ALLOC_WIDTH-1:0][$clog2(NUM_PHYS_REGS)-1:0]  alloc_regs,
    input  logic [$clog2(ALLOC_WIDTH+1)-1:0]                   commit_count,
    input  logic                                               flush,
    output logic [$clog2(NUM_PHYS_REGS):0]                     free_count,
    output logic                                               error
);
    localparam int PR_W      = $clog2(NUM_PHYS_REGS);
    localparam int PTR_W     = PR_W + 1;
    localparam int OCC_W     = PTR_W + 1;
    localparam int AC_W      = $clog2(ALLOC_WIDTH + 1);
    localparam int FC_W      = $clog2(FREE_WIDTH + 1);
    localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;

    logic [PR_W-1:0]  fifo_q [NUM_PHYS_REGS];
    logic [PR_W-1:0]  fifo_d [NUM_PHYS_REGS];
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] spec_q, spec_d;
    logic [PTR_W-1:0] ret_q, ret_d;
    logic             error_q, error_d;

    logic [FREE_WIDTH-1:0][FC_W-1:0]  free_pfx;
    logic [FC_W-1:0]                  n_free;
    logic [ALLOC_WIDTH-1:0][AC_W-1:0] alloc_pfx;
    logic [AC_W-1:0]                  n_req;

    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] outstanding;
    logic             overflow;
    logic             over_commit;

    lane_compactor #(.WIDTH(FREE_WIDTH)) u_free_cmp (
        .valid  (free_valid),
        .prefix (free_pfx),
        .total  (n_free)
    );

    lane_compactor #(.WIDTH(ALLOC_WIDTH)) u_alloc_cmp (
        .valid  (alloc_req),
        .prefix (alloc_pfx),
        .total  (n_req)
    );

    always_comb begin
        free_count  = tail_q - spec_q;
        alloc_ready = (free_count >= PTR_W'(n_req)) && !flush;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_regs[i] = alloc_req[i]
                ? fifo_q[PR_W'(spec_q + PTR_W'(alloc_pfx[i]))]
                : '0;
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (free_valid[j]) begin
                fifo_d[PR_W'(tail_q + PTR_W'(free_pfx[j]))] = free_regs[j];
            end
        end
        tail_d = tail_q + PTR_W'(n_free);

        occupancy = tail_q - ret_q;
        overflow  = ({1'b0, occupancy} + OCC_W'(n_free))
                    > OCC_W'(NUM_PHYS_REGS);

        // Committing more than was handed out means retirement is out of sync.
        outstanding = spec_q - ret_q;
        over_commit = PTR_W'(commit_count) > outstanding;
        ret_d = over_commit ? spec_q : ret_q + PTR_W'(commit_count);

        spec_d = spec_q;
        if (flush) begin
            spec_d = ret_d;
        end else if (alloc_ready) begin
            spec_d = spec_q + PTR_W'(n_req);
        end

        error_d = error_q | overflow | over_commit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_PHYS_REGS; k++) begin
                fifo_q[k] <= (k < INIT_FREE)
                    ? PR_W'(NUM_ARCH_REGS + 1 + k) : '0;
            end
            tail_q  <= PTR_W'(INIT_FREE);
            spec_q  <= '0;
            ret_q   <= '0;
            error_q <= 1'b0;
        end else begin
            assert (!overflow);
            fifo_q  <= fifo_d;
            tail_q  <= tail_d;
            spec_q  <= spec_d;
            ret_q   <= ret_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
endmodule

// File: tb/tb_free_reg_list.sv
// Directed bench for free_reg_list with a scoreboard of expected values.
module tb_free_reg_list;
    localparam int NP    = reg_pkg::NUM_PHYS_REGS;
    localparam int NA    = reg_pkg::NUM_ARCH_REGS;
    localparam int PR_W  = $clog2(NP);
    localparam int AW    = uop_pkg::INSTR_Q_WIDTH;
    localparam int FW    = 2 * uop_pkg::INSTR_Q_WIDTH + 2;
    localparam int CCW   = $clog2(AW + 1);

    logic                      clk;
    logic                      rst;
    logic [FW-1:0]             free_valid;
    logic [FW-1:0][PR_W-1:0]   free_regs;
    logic [AW-1:0]             alloc_req;
    logic                      alloc_ready;
    logic [AW-1:0][PR_W-1:0]   alloc_regs;
    logic [CCW-1:0]            commit_count;
    logic                      flush;
    logic [PR_W:0]             free_count;
    logic                      error;

    free_reg_list #(
        .NUM_PHYS_REGS (NP),
        .NUM_ARCH_REGS (NA),
        .ALLOC_WIDTH   (AW),
        .FREE_WIDTH    (FW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .free_valid   (free_valid),
        .free_regs    (free_regs),
        .alloc_req    (alloc_req),
        .alloc_ready  (alloc_ready),
        .alloc_regs   (alloc_regs),
        .commit_count (commit_count),
        .flush        (flush),
        .free_count   (free_count),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sb[$];

    task automatic expect_v(input int v);
        sb.push_back(v);
    endtask

    task automatic chk(input string tag, input int obs);
        int e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: got %0d, no expected value queued", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: got %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        free_valid   = '0;
        free_regs    = '0;
        alloc_req    = '0;
        commit_count = '0;
        flush        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic peek0(input string tag, input int v);
        alloc_req = 4'b0001;
        #1;
        expect_v(v);
        chk(tag, int'(alloc_regs[0]));
        alloc_req = '0;
        #1;
    endtask

    task automatic check_fc(input string tag, input int v);
        expect_v(v);
        chk(tag, int'(free_count));
    endtask

    task automatic alloc4(input string tag, input int first);
        alloc_req = 4'b1111;
        #1;
        expect_v(1);
        chk({tag, "_rdy"}, int'(alloc_ready));
        for (int i = 0; i < AW; i++) begin
            expect_v(first + i);
            chk(tag, int'(alloc_regs[i]));
        end
        tick();
        alloc_req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nxt;
        do_reset();

        check_fc("rst_free_count", 95);
        expect_v(0);
        chk("rst_error", int'(error));
        expect_v(1);
        chk("rst_ready_noreq", int'(alloc_ready));
        expect_v(0);
        chk("rst_lane0_noreq", int'(alloc_regs[0]));

        alloc4("alloc1111", 33);
        #1;
        check_fc("fc_after_4", 91);
        peek0("peek_37", 37);

        do_reset();
        alloc_req = 4'b1010;
        #1;
        expect_v(1);
        chk("sparse_rdy", int'(alloc_ready));
        expect_v(0);
        chk("sparse_l0", int'(alloc_regs[0]));
        expect_v(33);
        chk("sparse_l1", int'(alloc_regs[1]));
        expect_v(0);
        chk("sparse_l2", int'(alloc_regs[2]));
        expect_v(34);
        chk("sparse_l3", int'(alloc_regs[3]));
        tick();
        alloc_req = '0;
        #1;
        check_fc("fc_after_2", 93);

        do_reset();
        free_valid    = 10'b00_0010_0001;
        free_regs[0]  = 7'd7;
        free_regs[5]  = 7'd12;
        #1;
        check_fc("free_no_bypass", 95);
        tick();
        idle();
        #1;
        check_fc("free_next_cycle", 97);

        nxt = 33;
        for (int c = 0; c < 23; c++) begin
            alloc4("drain", nxt);
            nxt += 4;
        end
        alloc_req = 4'b0111;
        #1;
        for (int i = 0; i < 3; i++) begin
            expect_v(nxt + i);
            chk("drain_tail", int'(alloc_regs[i]));
        end
        tick();
        alloc_req = '0;
        #1;
        check_fc("fc_two_left", 2);

        alloc_req = 4'b0111;
        #1;
        expect_v(0);
        chk("short_not_ready", int'(alloc_ready));
        tick();
        alloc_req = '0;
        #1;
        check_fc("short_fc_hold", 2);
        peek0("short_head_hold", 7);

        alloc_req    = 4'b0111;
        free_valid   = 10'b00_0000_0100;
        free_regs[2] = 7'd20;
        #1;
        expect_v(0);
        chk("free_same_cycle_rdy", int'(alloc_ready));
        tick();
        free_valid = '0;
        #1;
        expect_v(1);
        chk("refill_rdy", int'(alloc_ready));
        expect_v(7);
        chk("refill_l0", int'(alloc_regs[0]));
        expect_v(12);
        chk("refill_l1", int'(alloc_regs[1]));
        expect_v(20);
        chk("refill_l2", int'(alloc_regs[2]));
        tick();
        alloc_req = '0;
        #1;
        check_fc("fc_empty", 0);

        for (int c = 0; c < 24; c++) begin
            commit_count = 3'd4;
            tick();
        end
        commit_count = 3'd2;
        tick();
        commit_count = '0;
        #1;
        expect_v(0);
        chk("commit_all_err", int'(error));

        for (int c = 0; c < 4; c++) begin
            free_valid = '1;
            for (int i = 0; i < FW; i++) begin
                free_regs[i] = PR_W'(c * 10 + i + 1);
            end
            tick();
        end
        idle();
        #1;
        check_fc("wrap_fc", 40);
        expect_v(0);
        chk("wrap_err", int'(error));
        for (int c = 0; c < 10; c++) begin
            alloc4("wrap_alloc", c * 4 + 1);
        end
        #1;
        check_fc("wrap_fc_empty", 0);

        do_reset();
        alloc4("pre_flush_a", 33);
        alloc4("pre_flush_b", 37);
        commit_count = 3'd3;
        flush        = 1'b1;
        alloc_req    = 4'b0001;
        #1;
        expect_v(0);
        chk("flush_rdy", int'(alloc_ready));
        tick();
        idle();
        #1;
        check_fc("flush_fc", 92);
        peek0("flush_peek", 36);

        commit_count = 3'd1;
        tick();
        commit_count = '0;
        #1;
        expect_v(1);
        chk("overcommit_err", int'(error));
        tick();
        expect_v(1);
        chk("err_sticky", int'(error));
        check_fc("overcommit_clamp_fc", 92);

        rst       = 1'b1;
        alloc_req = 4'b1111;
        tick();
        rst       = 1'b0;
        alloc_req = '0;
        #1;
        expect_v(0);
        chk("midrst_err", int'(error));
        check_fc("midrst_fc", 95);
        peek0("midrst_peek", 33);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/free_reg_list.md
Name: free_reg_list

Overview:
- Physical free register list (FRL). It is the consumer end of the freed-register interface driven by the retirement RAT.
- It accepts up to FREE_WIDTH freed physical registers per cycle from retirement.
- It hands out up to ALLOC_WIDTH free registers per cycle to rename.
- A speculative head and a retired head allow single-cycle recovery on pipeline flush.

Parameters:
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS (128): physical register count; power of two; also the FIFO depth.
- NUM_ARCH_REGS, reg_pkg::NUM_ARCH_REGS (32): architectural GPR count; NZCV occupies phys reg NUM_ARCH_REGS at reset.
- ALLOC_WIDTH, uop_pkg::INSTR_Q_WIDTH (4): rename allocation lanes.
- FREE_WIDTH, 2*uop_pkg::INSTR_Q_WIDTH+2 (10): retirement free lanes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- free_valid  in  FREE_WIDTH  per-lane freed-register valid from retirement RAT
- free_regs  in  FREE_WIDTH x PR_W  freed physical register IDs; PR_W = $clog2(NUM_PHYS_REGS)
- alloc_req  in  ALLOC_WIDTH  per-lane request for a destination register from rename
- alloc_ready  out  1  all requested lanes can be satisfied this cycle
- alloc_regs  out  ALLOC_WIDTH x PR_W  register granted to each requesting lane
- commit_count  in  $clog2(ALLOC_WIDTH+1)  number of committing uops this cycle that had allocated a register
- flush  in  1  discard all speculative allocations
- free_count  out  $clog2(NUM_PHYS_REGS)+1  registers currently allocatable
- error  out  1  sticky protocol violation

Behaviour:
- Storage: circular buffer fifo[NUM_PHYS_REGS] of PR_W-bit entries.
- Pointers: tail, spec_head and ret_head, each PR_W+1 bits (extra wrap bit).
- free_count = tail - spec_head. Occupancy = tail - ret_head, and is never more than NUM_PHYS_REGS.
- Reset state:
  - fifo[k] = NUM_ARCH_REGS+1+k for k < NUM_PHYS_REGS-NUM_ARCH_REGS-1.
  - spec_head = ret_head = 0; tail = NUM_PHYS_REGS-NUM_ARCH_REGS-1 (95).
  - error = 0.
  - Outputs after reset: free_count = 95; alloc_regs are a combinational peek of the state.
- Allocation (zero latency, combinational from state):
  - n_req = popcount(alloc_req).
  - Requesting lane i gets fifo[spec_head + number of set alloc_req bits below i]. Non-requesting lanes output 0.
  - alloc_ready = (free_count >= n_req) && !flush.
  - When alloc_ready is 1, spec_head += n_req at the clock edge.
  - Grant is all-or-nothing. If alloc_ready is 0, nothing is popped and rename holds the request.
  - n_req = 0 gives alloc_ready = 1 with no pop.
- Free:
  - Valid lanes are compacted in ascending lane order and written at tail, tail+1, and so on.
  - tail += popcount(free_valid).
  - Freed registers become allocatable the next cycle. There is no same-cycle bypass.
- Commit: ret_head += commit_count.
- Flush:
  - spec_head <= ret_head + commit_count (same-cycle commit is included).
  - Allocation is suppressed that cycle.
  - Frees and commits in the flush cycle are still applied.
- Simultaneous events: alloc, free and commit in the same cycle are all applied. Allocation decisions use pre-edge state only.
- Boundary conditions:
  - Pointers wrap modulo NUM_PHYS_REGS on the index bits.
  - Full: occupancy + pushes > NUM_PHYS_REGS sets error. The push still occurs and wraps; this is a design bug, and an assertion fires.
  - ret_head advancing beyond spec_head sets error, and the pointer is clamped to spec_head.
  - error holds until rst.
- Reset mid-operation: every pointer, fifo content and error returns to the reset state the next cycle. In-flight requests are dropped.

Decomposition:
- reg_pkg:
  - phys_reg_t typedef (PR_W-bit logic).
  - FRL_INIT_FREE = NUM_PHYS_REGS-NUM_ARCH_REGS-1.
- uop_pkg: INSTR_Q_WIDTH (already present).
- Sub-module lane_compactor #(WIDTH):
  - Input: valid vector.
  - Outputs: per-lane prefix popcount and total popcount.
  - Instantiated twice: once for free_valid, once for alloc_req.

Test Plan:
- Reset, then alloc_req=4'b1111 -> alloc_ready=1, alloc_regs=33,34,35,36; next cycle free_count=91 and lane0 peek=37.
- After reset, alloc_req=4'b1010 -> lane1=33, lane3=34, lanes 0 and 2 = 0; next cycle free_count=93.
- free_valid bits 0 and 5 with regs 7 and 12 -> free_count +2 next cycle, not in the same cycle. After draining the initial 95, allocation yields 7 then 12.
- Drain until free_count=2, then alloc_req=4'b0111 -> alloc_ready=0, spec_head unchanged, free_count stays 2. Then push one free -> next cycle alloc_ready=1.
- After reset, allocate 8 regs (33..40). Then in one cycle: commit_count=3, flush=1, alloc_req=4'b0001 -> no grant; next cycle free_count=92 and lane0 peek=36.
- Error and reset:
  - Commit with commit_count greater than outstanding allocations -> error=1 and stays 1.
  - Assert rst mid-stream -> next cycle error=0, free_count=95, lane0 peek=33.
